// File: rtl/door_keypad_if.sv
// rtl/door_keypad_if.sv - keypad/lock signal bundle for door_keypad
//
// Groups the keypad pulses, the lock command/result bus and the status
// outputs of door_keypad.
//   key_valid/key_code : digit key pulse and its value
//   key_set/key_enter  : program-password and commit key pulses
//   seg_out            : lock result code (01 open, 10 wrong, 00 none)
//   state/ps_num       : lock command (00 idle, 01 store, 10 check) and digit
//   busy/locked_out    : controller status
//   result_ok/_fail    : one-cycle check result pulses
// slave modport is the controller side, master modport the keypad/lock side.
interface door_keypad_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_set;
    logic       key_enter;
    logic [1:0] seg_out;
    logic [1:0] state;
    logic [3:0] ps_num;
    logic       busy;
    logic       locked_out;
    logic       result_ok;
    logic       result_fail;

    modport slave (
        input  key_valid, key_code, key_set, key_enter, seg_out,
        output state, ps_num, busy, locked_out, result_ok, result_fail
    );

    modport master (
        output key_valid, key_code, key_set, key_enter, seg_out,
        input  state, ps_num, busy, locked_out, result_ok, result_fail
    );
endinterface

// File: rtl/door_keypad.sv
// rtl/door_keypad.sv - single-digit door keypad controller with lockout
//
// Collects a digit from the keypad, then either programs it into the lock
// (state=01) or asks the lock to check it (state=10) and reports the result.
// MAX_FAIL consecutive failed checks lock all keys out for LOCKOUT_CYCLES.
// An entry left idle for TIMEOUT_CYCLES is discarded.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   rst_n : synchronous active-low reset
//   kp    : door_keypad_if.slave (keys and seg_out in; state, ps_num,
//           busy, locked_out, result_ok, result_fail out, all registered)
module door_keypad #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int MAX_FAIL       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    door_keypad_if.slave  kp
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    FAIL_MAX = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENTRY_SET = 3'd1,
        S_ENTRY_CHK = 3'd2,
        S_CMD_SET   = 3'd3,
        S_CMD_CHK   = 3'd4,
        S_LOCKOUT   = 3'd5
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic          cmd_cnt_q;      // 0 on first command cycle, 1 on second
    logic          held_q;         // ENTRY_SET has captured a digit
    logic [1:0]    fail_q, fail_d;
    logic [1:0]    fail_inc;
    logic [TW-1:0] to_q;
    logic [LW-1:0] lk_q;

    logic [1:0] state_q, state_d;
    logic [3:0] ps_q, ps_d;
    logic       busy_q, busy_d;
    logic       locked_q, locked_d;
    logic       ok_q, ok_d;
    logic       failp_q, failp_d;

    logic any_key;
    logic in_entry;
    logic in_cmd;
    logic chk_done;
    logic chk_pass;
    logic timed_out;

    assign any_key   = kp.key_valid | kp.key_set | kp.key_enter;
    assign in_entry  = (fsm_q == S_ENTRY_SET) || (fsm_q == S_ENTRY_CHK);
    assign in_cmd    = (fsm_q == S_CMD_SET) || (fsm_q == S_CMD_CHK);
    assign chk_done  = (fsm_q == S_CMD_CHK) && cmd_cnt_q;
    assign chk_pass  = (kp.seg_out == 2'b01);
    assign timed_out = !any_key && (to_q == TO_LAST);
    assign fail_inc  = fail_q + 2'd1;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            cmd_cnt_q <= 1'b0;
            held_q    <= 1'b0;
            fail_q    <= 2'd0;
            to_q      <= '0;
            lk_q      <= '0;
            state_q   <= 2'b00;
            ps_q      <= 4'd0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            ok_q      <= 1'b0;
            failp_q   <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            fail_q    <= fail_d;
            cmd_cnt_q <= in_cmd && (fsm_d == fsm_q);
            // Cleared whenever ENTRY_SET is left, so a fresh entry starts empty
            held_q    <= (fsm_d == S_ENTRY_SET) &&
                         (held_q || ((fsm_q == S_ENTRY_SET) && kp.key_valid));
            // Idle-key counter only runs while staying in an entry state
            to_q      <= (in_entry && (fsm_d == fsm_q) && !any_key) ? to_q + TW'(1) : '0;
            lk_q      <= ((fsm_q == S_LOCKOUT) && (fsm_d == S_LOCKOUT)) ? lk_q + LW'(1) : '0;
            state_q   <= state_d;
            ps_q      <= ps_d;
            busy_q    <= busy_d;
            locked_q  <= locked_d;
            ok_q      <= ok_d;
            failp_q   <= failp_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d  = fsm_q;
        fail_d = fail_q;
        case (fsm_q)
            S_IDLE: begin
                if (kp.key_set)
                    fsm_d = S_ENTRY_SET;
                else if (kp.key_valid)
                    fsm_d = S_ENTRY_CHK;
            end
            S_ENTRY_SET: begin
                // A digit in the same cycle as enter takes priority
                if (kp.key_valid)
                    fsm_d = S_ENTRY_SET;
                else if (kp.key_enter)
                    fsm_d = held_q ? S_CMD_SET : S_IDLE;
                else if (timed_out)
                    fsm_d = S_IDLE;
            end
            S_ENTRY_CHK: begin
                if (kp.key_valid)
                    fsm_d = S_ENTRY_CHK;
                else if (kp.key_enter)
                    fsm_d = S_CMD_CHK;
                else if (timed_out)
                    fsm_d = S_IDLE;
            end
            S_CMD_SET: begin
                if (cmd_cnt_q)
                    fsm_d = S_IDLE;
            end
            S_CMD_CHK: begin
                if (chk_done) begin
                    if (chk_pass) begin
                        fail_d = 2'd0;
                        fsm_d  = S_IDLE;
                    end else begin
                        fail_d = fail_inc;
                        fsm_d  = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (lk_q == LK_LAST) begin
                    fail_d = 2'd0;
                    fsm_d  = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // Output logic: values the output registers take at the next edge,
    // derived from the upcoming state so outputs line up with the FSM
    always_comb begin
        state_d  = 2'b00;
        ps_d     = ps_q;
        busy_d   = (fsm_d != S_IDLE);
        locked_d = (fsm_d == S_LOCKOUT);
        ok_d     = chk_done && chk_pass;
        failp_d  = chk_done && !chk_pass;
        if (fsm_d == S_CMD_SET)
            state_d = 2'b01;
        else if (fsm_d == S_CMD_CHK)
            state_d = 2'b10;
        // key_set beats key_valid in IDLE, so the digit is dropped then
        if (kp.key_valid && (in_entry || ((fsm_q == S_IDLE) && !kp.key_set)))
            ps_d = kp.key_code;
    end

    assign kp.state       = state_q;
    assign kp.ps_num      = ps_q;
    assign kp.busy        = busy_q;
    assign kp.locked_out  = locked_q;
    assign kp.result_ok   = ok_q;
    assign kp.result_fail = failp_q;

endmodule

// File: tb/tb_door_keypad.sv
// tb/tb_door_keypad.sv - directed self-checking bench for door_keypad
module tb_door_keypad;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    door_keypad_if kp ();

    door_keypad #(
        .TIMEOUT_CYCLES(10),
        .LOCKOUT_CYCLES(20),
        .MAX_FAIL(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic v, input logic [3:0] code, input logic s, input logic e);
        kp.key_valid = v;
        kp.key_code  = code;
        kp.key_set   = s;
        kp.key_enter = e;
        tick();
        kp.key_valid = 1'b0;
        kp.key_set   = 1'b0;
        kp.key_enter = 1'b0;
    endtask

    // Enter one digit, commit it as a check, and return on the result cycle
    task automatic do_check(input logic [3:0] code, input logic [1:0] seg);
        kp.seg_out = seg;
        press(1'b1, code, 1'b0, 1'b0);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        tick();
        kp.seg_out = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_cycles;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'd0;
        kp.key_set   = 1'b0;
        kp.key_enter = 1'b0;
        kp.seg_out   = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_state", kp.state, 0);
        check("rst_ps_num", kp.ps_num, 0);
        check("rst_busy", kp.busy, 0);
        check("rst_locked", kp.locked_out, 0);
        check("rst_ok", kp.result_ok, 0);
        check("rst_fail", kp.result_fail, 0);
        rst_n = 1'b1;
        tick();

        // Program digit 5
        press(1'b0, 4'd0, 1'b1, 1'b0);
        check("prog_busy", kp.busy, 1);
        check("prog_state_entry", kp.state, 0);
        press(1'b1, 4'd5, 1'b0, 1'b0);
        check("prog_ps", kp.ps_num, 5);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("prog_state_c1", kp.state, 1);
        check("prog_ps_c1", kp.ps_num, 5);
        tick();
        check("prog_state_c2", kp.state, 1);
        check("prog_ps_c2", kp.ps_num, 5);
        tick();
        check("prog_state_done", kp.state, 0);
        check("prog_busy_done", kp.busy, 0);

        // Check pass with digit 9
        kp.seg_out = 2'b01;
        press(1'b1, 4'd9, 1'b0, 1'b0);
        check("chk_ps", kp.ps_num, 9);
        check("chk_busy", kp.busy, 1);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("chk_state_c1", kp.state, 2);
        check("chk_ok_c1", kp.result_ok, 0);
        tick();
        check("chk_state_c2", kp.state, 2);
        check("chk_ok_c2", kp.result_ok, 0);
        tick();
        kp.seg_out = 2'b00;
        check("chk_state_done", kp.state, 0);
        check("chk_ok_pulse", kp.result_ok, 1);
        check("chk_fail_quiet", kp.result_fail, 0);
        tick();
        check("chk_ok_one_cycle", kp.result_ok, 0);

        // Fail, pass (clears count), fail, fail: no lockout yet
        do_check(4'd1, 2'b10);
        check("f1_fail", kp.result_fail, 1);
        check("f1_lock", kp.locked_out, 0);
        do_check(4'd2, 2'b01);
        check("p_ok", kp.result_ok, 1);
        do_check(4'd3, 2'b10);
        check("f2_fail", kp.result_fail, 1);
        do_check(4'd4, 2'b00);
        check("f3_fail", kp.result_fail, 1);
        check("f3_lock", kp.locked_out, 0);
        check("f3_busy", kp.busy, 0);

        // Third consecutive fail locks out
        do_check(4'd8, 2'b10);
        check("lk_fail", kp.result_fail, 1);
        check("lk_state", kp.state, 0);
        check("lk_locked", kp.locked_out, 1);
        lock_cycles = 1;
        press(1'b1, 4'd7, 1'b0, 1'b1);
        if (kp.locked_out) lock_cycles++;
        check("lk_ps_hold", kp.ps_num, 8);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (kp.locked_out) lock_cycles++;
            else break;
        end
        check("lk_cycles", lock_cycles, 20);
        check("lk_busy_after", kp.busy, 0);
        check("lk_state_after", kp.state, 0);
        do_check(4'd2, 2'b10);
        check("lk_count_cleared", kp.locked_out, 0);

        // Entry timeout after 10 idle cycles
        press(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("to_busy_9", kp.busy, 1);
        tick();
        check("to_busy_10", kp.busy, 0);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("to_enter_state", kp.state, 0);
        check("to_enter_busy", kp.busy, 0);
        tick();
        check("to_enter_state2", kp.state, 0);

        // key_set + key_valid in IDLE: digit dropped, enter with no digit
        press(1'b1, 4'd3, 1'b1, 1'b0);
        check("c1_busy", kp.busy, 1);
        check("c1_ps_dropped", kp.ps_num, 2);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("c1_no_cmd", kp.state, 0);
        check("c1_idle", kp.busy, 0);

        // key_valid + key_enter together: digit loaded, no command
        press(1'b1, 4'd6, 1'b0, 1'b0);
        press(1'b1, 4'd4, 1'b0, 1'b1);
        check("c2_ps", kp.ps_num, 4);
        check("c2_no_cmd", kp.state, 0);
        check("c2_busy", kp.busy, 1);

        // Reset during CMD_CHK aborts the command
        kp.seg_out = 2'b01;
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("c3_state_chk", kp.state, 2);
        rst_n = 1'b0;
        tick();
        check("c3_rst_state", kp.state, 0);
        check("c3_rst_ok", kp.result_ok, 0);
        check("c3_rst_ps", kp.ps_num, 0);
        rst_n = 1'b1;
        tick();
        check("c3_ok_after", kp.result_ok, 0);
        check("c3_fail_after", kp.result_fail, 0);
        tick();
        check("c3_ok_after2", kp.result_ok, 0);
        check("c3_busy_after", kp.busy, 0);
        kp.seg_out = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/door_keypad.md
DOOR_KEYPAD -- requirements
Module: door_keypad

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles in an entry state before the entry is discarded.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 5000: cycles all keys are ignored after MAX_FAIL failed checks.
REQ-003 SHALL have parameter MAX_FAIL, default 3, range 1..3: consecutive failed checks that trigger lockout.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port key_valid  input  1  one-cycle pulse: a digit key was pressed.
REQ-007 SHALL have port key_code  input  4  digit value, qualified by key_valid.
REQ-008 SHALL have port key_set  input  1  one-cycle pulse: program-password key.
REQ-009 SHALL have port key_enter  input  1  one-cycle pulse: commit key.
REQ-010 SHALL have port seg_out  input  2  lock result code: 01 open, 10 wrong, 00 none.
REQ-011 SHALL have port state  output  2  lock command: 00 idle, 01 store password, 10 check password.
REQ-012 SHALL have port ps_num  output  4  digit presented to the lock.
REQ-013 SHALL have port busy  output  1  high in every FSM state except IDLE.
REQ-014 SHALL have port locked_out  output  1  high exactly while in LOCKOUT.
REQ-015 SHALL have port result_ok  output  1  one-cycle pulse: check succeeded.
REQ-016 SHALL have port result_fail  output  1  one-cycle pulse: check failed.

Function
REQ-017 SHALL implement FSM states IDLE, ENTRY_SET, ENTRY_CHK, CMD_SET, CMD_CHK, LOCKOUT.
REQ-018 IDLE: key_set -> ENTRY_SET; key_valid -> ENTRY_CHK with ps_num <= key_code; if both occur in the same cycle, key_set wins and the digit is discarded.
REQ-019 ENTRY_SET/ENTRY_CHK: each key_valid loads ps_num <= key_code (last digit wins) and marks a digit held; key_set is ignored.
REQ-020 ENTRY_SET with key_valid for a new digit -> ENTRY_SET, digit held; key_enter with a digit held -> CMD_SET; key_enter with no digit held -> IDLE, no command.
REQ-021 ENTRY_CHK key_enter -> CMD_CHK; ENTRY_CHK always holds a digit.
REQ-022 key_valid and key_enter in the same cycle in an entry state: digit loaded, key_enter ignored.
REQ-023 Entry timeout: a cycle counter clears on any key pulse; when it reaches TIMEOUT_CYCLES with no key, the FSM -> IDLE and the entry is discarded.
REQ-024 CMD_SET: drive state=01 for exactly 2 cycles, ps_num stable; then -> IDLE; the fail count is unchanged.
REQ-025 CMD_CHK: drive state=10 for exactly 2 cycles; sample seg_out on the 2nd cycle.
REQ-026 CMD_CHK with seg_out==01: pulse result_ok for 1 cycle, clear the fail count, -> IDLE.
REQ-027 CMD_CHK with any other seg_out value: pulse result_fail for 1 cycle, increment the 2-bit fail count; if the count reaches MAX_FAIL -> LOCKOUT, else -> IDLE.
REQ-028 The result pulse SHALL occur in the first cycle after CMD_CHK, coincident with state returning to 00.
REQ-029 state SHALL be 00 in all states other than CMD_SET and CMD_CHK.
REQ-030 All key pulses SHALL be ignored in CMD_SET, CMD_CHK and LOCKOUT.
REQ-031 LOCKOUT: count LOCKOUT_CYCLES cycles, then clear the fail count and -> IDLE; locked_out drops in the cycle IDLE is entered.
REQ-032 ps_num SHALL hold its last value outside the entry states.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n low at a clock edge SHALL force IDLE, state=00, ps_num=0, busy=0, locked_out=0, result_ok=0, result_fail=0, fail count=0, timeout and lockout counters=0.
REQ-035 Reset mid-command SHALL abort the command: state=00 in the cycle after the reset edge, and no result pulse.

Verification
REQ-036 Program: key_set, key_valid code=D, key_enter -> state=01 for 2 cycles with ps_num=D, then 00; busy low after.
REQ-037 Check pass: key_valid code=D, key_enter, seg_out=01 -> state=10 for 2 cycles, one result_ok pulse, fail count=0.
REQ-038 Lockout (MAX_FAIL=3, LOCKOUT_CYCLES=20): three checks with seg_out=10 -> three result_fail pulses, locked_out high 20 cycles, keys ignored, then IDLE.
REQ-039 Timeout (TIMEOUT_CYCLES=10): key_set, then no keys for 10 cycles -> IDLE; a later key_enter issues no command.
REQ-040 Corners: key_set+key_valid in the same cycle in IDLE -> ENTRY_SET, digit dropped; key_valid+key_enter in the same cycle -> digit loaded, no command; rst_n low during CMD_CHK -> state=00, no result pulse.
